// File: rtl/prbs_gen_multi.sv
// Parallel PRBS7/9/15/31 generator: DATA_W consecutive sequence bits per enabled clock,
// with run-time seed/mode load, single-bit error injection and a produced-word counter.
module prbs_gen_multi #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [1:0]  MODE_DEF = 2'd0,
  parameter logic [30:0] SEED_DEF = 31'h7FFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [30:0]       seed_in,
  input  logic              inj_err,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [1:0]        mode_q,
  output logic [31:0]       word_cnt
);

  function automatic logic [30:0] poly_mask(input logic [1:0] m);
    case (m)
      2'd0:    poly_mask = 31'h0000_007F;
      2'd1:    poly_mask = 31'h0000_01FF;
      2'd2:    poly_mask = 31'h0000_7FFF;
      default: poly_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic poly_fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    poly_fb = s[6]  ^ s[5];
      2'd1:    poly_fb = s[8]  ^ s[4];
      2'd2:    poly_fb = s[14] ^ s[13];
      default: poly_fb = s[30] ^ s[27];
    endcase
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by all ones.
  function automatic logic [30:0] guard_seed(input logic [30:0] seed, input logic [1:0] m);
    logic [30:0] masked;
    masked = seed & poly_mask(m);
    guard_seed = (masked == 31'd0) ? poly_mask(m) : masked;
  endfunction

  logic              rst_meta;
  logic              rst_sync;
  logic [30:0]       lfsr_q;
  logic              inj_pend;
  logic [30:0]       s_walk;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Unrolled DATA_W steps; bit k of the word is the (k+1)-th bit in time.
  always_comb begin
    s_walk = lfsr_q;
    word   = '0;
    for (int k = 0; k < int'(DATA_W); k++) begin
      word[k] = poly_fb(s_walk, mode_q);
      s_walk  = ((s_walk << 1) | {30'd0, word[k]}) & poly_mask(mode_q);
    end
    word_x    = word;
    word_x[0] = word[0] ^ inj_pend;
  end

  // Producer contract: en=1 with load=0 yields one word that edge, flagged by out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      word_cnt  <= 32'd0;
      mode_q    <= MODE_DEF;
      lfsr_q    <= guard_seed(SEED_DEF, MODE_DEF);
      inj_pend  <= 1'b0;
    end else if (rst_sync) begin
      out       <= '0;
      out_valid <= 1'b0;
      word_cnt  <= 32'd0;
      mode_q    <= MODE_DEF;
      lfsr_q    <= guard_seed(SEED_DEF, MODE_DEF);
      inj_pend  <= 1'b0;
    end else if (load) begin
      mode_q    <= mode;
      lfsr_q    <= guard_seed(seed_in, mode);
      word_cnt  <= 32'd0;
      out_valid <= 1'b0;
      inj_pend  <= inj_pend | inj_err;
    end else if (en) begin
      out       <= word_x;
      out_valid <= 1'b1;
      word_cnt  <= word_cnt + 32'd1;
      lfsr_q    <= s_walk;
      // A pulse arriving while a pending error is consumed merges into that error.
      inj_pend  <= inj_pend ? 1'b0 : inj_err;
    end else begin
      out_valid <= 1'b0;
      inj_pend  <= inj_pend | inj_err;
    end
  end

endmodule

// File: doc/prbs_gen_multi.md
# prbs_gen_multi

Parametrised parallel PRBS generator for LVDS/serdes link test. It produces DATA_W consecutive bits of a selectable standard PRBS sequence (PRBS7/9/15/31) per clock. It also supports run-time seed/mode load, a clock enable, single-bit error injection and a produced-word counter. It sits in front of the LVDS TX serialiser and pairs with a matching checker on the RX side.

## Interface
- DATA_W, 8, bits produced per clock; legal range 1..64
- MODE_DEF, 0, polynomial selected out of reset (0..3)
- SEED_DEF, 31'h7FFF_FFFF, reset seed; masked to the active polynomial length N
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance generator one word this cycle
- load  in  1  load seed_in and mode into generator (one-cycle pulse)
- mode  in  2  polynomial select, sampled only on load: 0=PRBS7, 1=PRBS9, 2=PRBS15, 3=PRBS31
- seed_in  in  31  seed, masked to N bits on load
- inj_err  in  1  request single-bit error on next produced word
- out  out  DATA_W  PRBS word; out[0] is the earliest bit in time
- out_valid  out  1  out holds a new word produced this cycle
- mode_q  out  2  polynomial currently in use
- word_cnt  out  32  words produced since reset/load

## Operation
- Reset sync: rst asserts all state asynchronously. Deassertion passes through a 2-flop synchroniser (rst_sync). The generator stays in reset while rst_sync is high.
- Reset values: out=0, out_valid=0, word_cnt=0, mode_q=MODE_DEF, LFSR=SEED_DEF masked to N(MODE_DEF), inject pending=0.
- LFSR: Fibonacci, 31-bit register s, low N bits used. N/taps: PRBS7 N=7 taps 7,6; PRBS9 N=9 taps 9,5; PRBS15 N=15 taps 15,14; PRBS31 N=31 taps 31,28.
- One step: b = s[tapA-1] ^ s[tapB-1]; s <= {s[N-2:0], b}; emitted bit = b.
- Per enabled cycle: DATA_W steps are unrolled combinationally. Step k emits out[k-1]. The LFSR is updated to the state after DATA_W steps.
- Lock-up guard: a masked seed of all zeros (from SEED_DEF or seed_in) loads all-ones(N) instead.
- load=1: mode_q<=mode; s<=masked seed_in (with lock-up guard); word_cnt<=0; out_valid<=0; out holds its value. load has priority over en.
- en=1, load=0: out<=word, out_valid<=1, word_cnt<=word_cnt+1, wrapping 0xFFFF_FFFF to 0.
- en=0, load=0: s, out and word_cnt hold; out_valid<=0.
- Error injection: an inj_err pulse sets a pending flag. The next produced word has out[0] inverted and the flag then clears. The LFSR sequence itself is not altered. Pulses while pending merge into one error. load does not clear the flag. inj_err in the same cycle as a produced word with no flag pending applies to the following word, not the current one.
- Mode changes take effect only through load; mode is ignored otherwise.

## Timing
- rst falling: rst_sync falls after 2 clk edges. Edge 3 is the first edge that can produce a word.
- Latency: en sampled high at edge k gives out/out_valid updated at edge k, visible in cycle k..k+1.
- Throughput: one word per clock while en=1; no bubbles.
- load at edge k: first word from the new seed at the first en edge after k; out_valid is low after edge k.
- rst asserted mid-run: outputs go to reset values immediately, without waiting for a clock; pending error is cleared.
- All outputs registered; no combinational input-to-output path.

## Test plan
- DATA_W=8, reset with MODE_DEF=0, SEED_DEF=7F, en=1 continuous -> first out=8'h40 at the 3rd edge after rst release, out_valid=1, word_cnt=1.
- DATA_W=1, PRBS7 and PRBS9 -> bitstream periodic with exactly 127 / 511 bits, no all-zero run longer than 6 / 8, matches software LFSR model; repeat for PRBS15/31 against model for 10k words at DATA_W=32.
- load with mode=2, seed_in=0 -> mode_q=2, LFSR = 15'h7FFF, word_cnt=0; the following words match the model seeded with all ones; load+en in the same cycle -> out_valid=0.
- inj_err pulses (single, double back-to-back, during en=0) -> exactly one word with out[0] inverted per pending flag; next words match the model with no offset.
- en toggled pseudo-randomly -> the concatenated valid words equal the continuous sequence; word_cnt preset near wrap (via long run or force) wraps 0xFFFF_FFFF->0.
- rst asserted mid-stream, without a clock edge -> outputs reset immediately; after release the sequence restarts from SEED_DEF with the 2-cycle sync delay.
